// File: rtl/alsu_mon_pkg.sv
// alsu_mon_pkg: shared types, rule indices and the invalid-op predicate for the ALSU runtime monitor
package alsu_mon_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, MONITOR = 2'd1, FAULT = 2'd2} state_e;
   localparam int R_RST = 0;
   localparam int R_OUT = 1;
   localparam int R_LED = 2;
   typedef struct packed {
      logic       vld;
      logic       invalid;
      logic [2:0] opcode;
      logic [1:0] red;
   } mon_entry_t;
   localparam int ENTRY_W = $bits(mon_entry_t);
   function automatic logic is_invalid(input logic [2:0] op, input logic [1:0] red);
      return ((red[1] | red[0]) & (op[1] | op[2])) | (op[1] & op[2]);
   endfunction
endpackage

// File: rtl/alsu_mon_delay_line.sv
// alsu_mon_delay_line: DEPTH-stage shift register of monitor entries, flushed by rst
module alsu_mon_delay_line
   import alsu_mon_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic               any_vld
);
   localparam int W = ENTRY_W;
   logic [DEPTH*W-1:0] sr_q, sr_d;
   logic [(DEPTH+1)*W-1:0] sh;
   assign sh = {sr_q, din};
   assign dout = sr_q[DEPTH*W-1 -: W];
   // vld is the MSB of each packed entry
   always_comb begin
      sr_d = sh[DEPTH*W-1:0];
      any_vld = 1'b0;
      for (int i = 0; i < DEPTH; i++) any_vld = any_vld | sr_q[i*W + W - 1];
   end
   always_ff @(posedge clk) begin
      if (rst) sr_q <= '0;
      else sr_q <= sr_d;
   end
endmodule

// File: rtl/alsu_runtime_monitor.sv
// alsu_runtime_monitor: checks ALSU out/leds LATENCY cycles after its inputs; sticky flags, saturating count, FSM.
// ALSU_MON_CAPTURE_EN builds first-failure opcode/red capture registers; otherwise cap_* are tied to 0.
module alsu_runtime_monitor
   import alsu_mon_pkg::*;
#(
   parameter int OUT_W   = 6,
   parameter int LED_W   = 16,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [2:0]       opcode,
   input  logic             red_op_A,
   input  logic             red_op_B,
   input  logic [OUT_W-1:0] out,
   input  logic [LED_W-1:0] leds,
   input  logic             err_clr,
   output logic [2:0]       fail_vec,
   output logic             fail_any,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       mon_state,
   output logic [2:0]       cap_opcode,
   output logic [1:0]       cap_red
);
   mon_entry_t push_e, chk_e;
   logic [ENTRY_W-1:0] chk_bits;
   logic pipe_vld, chk_on;
   logic [2:0] viol;
   logic [1:0] n_viol;
   logic [CNT_W+1:0] sum;
   logic rst_seen_q, rst_seen_d;
   logic [LED_W-1:0] leds_q, leds_d;
   logic [2:0] fail_q, fail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_e state_q, state_d;
   alsu_mon_delay_line #(.DEPTH(LATENCY)) u_dl (
      .clk    (clk),
      .rst    (rst),
      .din    (push_e),
      .dout   (chk_bits),
      .any_vld(pipe_vld)
   );
   always_comb begin
      push_e = '{vld: enable, invalid: is_invalid(opcode, {red_op_A, red_op_B}), opcode: opcode, red: {red_op_A, red_op_B}};
      chk_e = mon_entry_t'(chk_bits);
      chk_on = chk_e.vld && state_q != IDLE;
      viol[R_RST] = rst_seen_q && (out != '0 || leds != '0);
      viol[R_OUT] = chk_on && chk_e.invalid && out != '0;
      viol[R_LED] = chk_on && (chk_e.invalid ? leds != ~leds_q : leds != '0);
      n_viol = {1'b0, viol[0]} + {1'b0, viol[1]} + {1'b0, viol[2]};
      // err_clr zeroes the base first so a same-cycle violation still lands
      sum = (CNT_W+2)'(err_clr ? '0 : cnt_q) + (CNT_W+2)'(n_viol);
      cnt_d = |sum[CNT_W+1:CNT_W] ? '1 : sum[CNT_W-1:0];
      fail_d = (err_clr ? 3'b000 : fail_q) | viol;
      rst_seen_d = 1'b0;
      leds_d = leds;
      state_d = (state_q == IDLE)    ? (enable ? MONITOR : IDLE)
              : (state_q == MONITOR) ? (|viol ? FAULT : (!enable && !pipe_vld) ? IDLE : MONITOR)
              : (err_clr && !(|viol)) ? MONITOR : FAULT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_seen_q <= 1'b1;
         leds_q <= '0;
         fail_q <= '0;
         cnt_q <= '0;
         state_q <= IDLE;
      end else begin
         rst_seen_q <= rst_seen_d;
         leds_q <= leds_d;
         fail_q <= fail_d;
         cnt_q <= cnt_d;
         state_q <= state_d;
      end
   end
   assign fail_vec = fail_q;
   assign fail_any = |fail_q;
   assign err_cnt = cnt_q;
   assign mon_state = state_q;
`ifdef ALSU_MON_CAPTURE_EN
   logic cap_done_q, cap_done_d, cap_load;
   logic [2:0] cap_opcode_q, cap_opcode_d;
   logic [1:0] cap_red_q, cap_red_d;
   // an R0-only failure has no meaningful entry, so it captures zeros
   always_comb begin
      cap_load = |viol && (err_clr || !cap_done_q);
      cap_opcode_d = cap_load ? ((viol[R_OUT] | viol[R_LED]) ? chk_e.opcode : 3'b000) : cap_opcode_q;
      cap_red_d = cap_load ? ((viol[R_OUT] | viol[R_LED]) ? chk_e.red : 2'b00) : cap_red_q;
      cap_done_d = (cap_done_q && !err_clr) || |viol;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_done_q <= 1'b0;
         cap_opcode_q <= '0;
         cap_red_q <= '0;
      end else begin
         cap_done_q <= cap_done_d;
         cap_opcode_q <= cap_opcode_d;
         cap_red_q <= cap_red_d;
      end
   end
   assign cap_opcode = cap_opcode_q;
   assign cap_red = cap_red_q;
`else
   logic unused_cap;
   assign unused_cap = ^{chk_e.opcode, chk_e.red};
   assign cap_opcode = 3'b000;
   assign cap_red = 2'b00;
`endif
endmodule

// File: tb/tb_alsu_runtime_monitor.sv
// tb_alsu_runtime_monitor: randomized + directed bench with an edge-indexed history model for two monitor configurations
module tb_alsu_runtime_monitor;
   localparam int N = 4096;
   localparam int LAT[2] = '{1, 3};
   localparam int CMAX[2] = '{255, 3};
   logic clk = 1'b0;
   logic rst, enable, red_op_A, red_op_B, err_clr;
   logic [2:0] opcode;
   logic [5:0] out_a, out_b;
   logic [15:0] leds_a, leds_b;
   logic [2:0] fv_a, fv_b, cop_a, cop_b;
   logic fa_a, fa_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b, st_a, st_b, cred_a, cred_b;
   logic en_h[N], rst_h[N], clr_h[N];
   logic [2:0] op_h[N];
   logic [1:0] red_h[N];
   logic [5:0] out_h[2][N];
   logic [15:0] leds_h[2][N];
   logic [2:0] e_fail[2], e_cop[2];
   logic [1:0] e_cred[2];
   int e_cnt[2], e_st[2];
`ifdef ALSU_MON_CAPTURE_EN
   logic e_done[2];
`endif
   int cyc = 0, checks = 0, errors = 0;
   logic busy;

   always #5 clk = ~clk;

   alsu_runtime_monitor dut_a (
      .clk(clk), .rst(rst), .enable(enable), .opcode(opcode), .red_op_A(red_op_A), .red_op_B(red_op_B),
      .out(out_a), .leds(leds_a), .err_clr(err_clr), .fail_vec(fv_a), .fail_any(fa_a), .err_cnt(cnt_a),
      .mon_state(st_a), .cap_opcode(cop_a), .cap_red(cred_a)
   );
   alsu_runtime_monitor #(.LATENCY(3), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .opcode(opcode), .red_op_A(red_op_A), .red_op_B(red_op_B),
      .out(out_b), .leds(leds_b), .err_clr(err_clr), .fail_vec(fv_b), .fail_any(fa_b), .err_cnt(cnt_b),
      .mon_state(st_b), .cap_opcode(cop_b), .cap_red(cred_b)
   );

   function automatic logic rst_at(input int k);
      return (k >= 0) ? rst_h[k] : 1'b0;
   endfunction
   // entry pushed at edge p still sits in the pipeline at edge j if it was valid and no reset hit it since
   function automatic logic alive(input int p, input int j);
      if (p < 0) return 1'b0;
      if (!en_h[p]) return 1'b0;
      for (int k = p; k < j; k++) if (rst_h[k]) return 1'b0;
      return 1'b1;
   endfunction
   function automatic logic inv_of(input logic [2:0] op, input logic [1:0] red);
      return (op >= 3'd6) || (red != 2'b00 && op >= 3'd2);
   endfunction

   task automatic model(input int i, input int j);
      logic r0, r1, r2, clr, chk, inv, pend;
      logic [15:0] pl;
      int p, n;
      if (rst_h[j]) begin
         e_fail[i] = 0; e_cnt[i] = 0; e_st[i] = 0; e_cop[i] = 0; e_cred[i] = 0;
`ifdef ALSU_MON_CAPTURE_EN
         e_done[i] = 0;
`endif
         return;
      end
      p = j - LAT[i];
      pl = (j > 0 && !rst_at(j-1)) ? leds_h[i][j-1] : 16'h0000;
      chk = alive(p, j) && e_st[i] != 0;
      inv = (p >= 0) ? inv_of(op_h[p], red_h[p]) : 1'b0;
      r0 = rst_at(j-1) && (out_h[i][j] != 0 || leds_h[i][j] != 0);
      r1 = chk && inv && out_h[i][j] != 0;
      r2 = chk && (inv ? leds_h[i][j] != ~pl : leds_h[i][j] != 0);
      n = int'(r0) + int'(r1) + int'(r2);
      clr = clr_h[j];
      pend = 1'b0;
      for (int q = j - LAT[i]; q < j; q++) if (alive(q, j)) pend = 1'b1;
`ifdef ALSU_MON_CAPTURE_EN
      if (n > 0 && (clr || !e_done[i])) begin
         e_cop[i] = (r1 || r2) ? op_h[p] : 3'b000;
         e_cred[i] = (r1 || r2) ? red_h[p] : 2'b00;
      end
      e_done[i] = (e_done[i] && !clr) || n > 0;
`endif
      e_fail[i] = (clr ? 3'b000 : e_fail[i]) | {r2, r1, r0};
      e_cnt[i] = (clr ? 0 : e_cnt[i]) + n;
      if (e_cnt[i] > CMAX[i]) e_cnt[i] = CMAX[i];
      case (e_st[i])
         0: if (en_h[j]) e_st[i] = 1;
         1: if (n > 0) e_st[i] = 2; else if (!en_h[j] && !pend) e_st[i] = 0;
         default: if (clr && n == 0) e_st[i] = 1;
      endcase
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, got, exp, cyc - 1);
      end
   endtask

   task automatic cmp_inst(input string p, input int i, input logic [2:0] fv, input logic fa, input int cnt,
                           input logic [1:0] st, input logic [2:0] cop, input logic [1:0] cred);
      chk({p, ".fail_vec"}, int'(fv), int'(e_fail[i]));
      chk({p, ".fail_any"}, int'(fa), int'(|e_fail[i]));
      chk({p, ".err_cnt"}, cnt, e_cnt[i]);
      chk({p, ".mon_state"}, int'(st), e_st[i]);
      chk({p, ".cap_opcode"}, int'(cop), int'(e_cop[i]));
      chk({p, ".cap_red"}, int'(cred), int'(e_cred[i]));
   endtask

   task automatic step();
      @(posedge clk);
      en_h[cyc] = enable; rst_h[cyc] = rst; clr_h[cyc] = err_clr;
      op_h[cyc] = opcode; red_h[cyc] = {red_op_A, red_op_B};
      out_h[0][cyc] = out_a; leds_h[0][cyc] = leds_a;
      out_h[1][cyc] = out_b; leds_h[1][cyc] = leds_b;
      model(0, cyc);
      model(1, cyc);
      cyc++;
      @(negedge clk);
      cmp_inst("a", 0, fv_a, fa_a, int'(cnt_a), st_a, cop_a, cred_a);
      cmp_inst("b", 1, fv_b, fa_b, int'(cnt_b), st_b, cop_b, cred_b);
   endtask

   // a well-behaved ALSU response for the next edge, derived from the model's view
   task automatic good(input int i, output logic [5:0] o, output logic [15:0] l);
      int j, p;
      logic [15:0] pl;
      j = cyc;
      p = j - LAT[i];
      o = 6'($urandom);
      l = 16'($urandom);
      pl = (j > 0 && !rst_at(j-1)) ? leds_h[i][j-1] : 16'h0000;
      if (rst_at(j-1)) begin
         o = 0; l = 0;
      end else if (alive(p, j) && e_st[i] != 0) begin
         if (inv_of(op_h[p], red_h[p])) begin o = 0; l = ~pl; end
         else l = 0;
      end
   endtask

   initial begin
      rst = 1; enable = 0; err_clr = 0; opcode = 0; red_op_A = 0; red_op_B = 0;
      out_a = 0; leds_a = 0; out_b = 0; leds_b = 0;
      step();
      chk("reset fail_vec", int'(fv_a), 0);
      chk("reset err_cnt", int'(cnt_a), 0);
      chk("reset mon_state", int'(st_a), 0);
      chk("reset cap_opcode", int'(cop_a), 0);
      // R0 violation right after reset
      rst = 0; out_a = 6'h05; leds_a = 0; good(1, out_b, leds_b);
      step();
      chk("t1 fail_vec", int'(fv_a), 3'b001);
      chk("t1 err_cnt", int'(cnt_a), 1);
      chk("t1 mon_state", int'(st_a), 0);
      // clean invalid op: leds must toggle
      enable = 1; opcode = 3'b110; err_clr = 1; out_a = 0; leds_a = 0; good(1, out_b, leds_b);
      step();
      chk("t2 clr fail_vec", int'(fv_a), 0);
      chk("t2 mon_state", int'(st_a), 1);
      enable = 0; err_clr = 0; out_a = 0; leds_a = 16'hFFFF; good(1, out_b, leds_b);
      step();
      chk("t2 fail_vec", int'(fv_a), 0);
      chk("t2 err_cnt", int'(cnt_a), 0);
      chk("t2 mon_state", int'(st_a), 1);
      // invalid op answered with nonzero out and non-toggled leds
      enable = 1; opcode = 3'b010; red_op_A = 1; out_a = 0; leds_a = 0; good(1, out_b, leds_b);
      step();
      enable = 0; opcode = 0; red_op_A = 0; out_a = 6'h03; leds_a = 0; good(1, out_b, leds_b);
      step();
      chk("t3 fail_vec", int'(fv_a), 3'b110);
      chk("t3 err_cnt", int'(cnt_a), 2);
      chk("t3 mon_state", int'(st_a), 2);
`ifdef ALSU_MON_CAPTURE_EN
      chk("t3 cap_opcode", int'(cop_a), 3'b010);
      chk("t3 cap_red", int'(cred_a), 2'b10);
`else
      chk("t3 cap_opcode", int'(cop_a), 0);
      chk("t3 cap_red", int'(cred_a), 0);
`endif
      err_clr = 1; out_a = 0; leds_a = 0; good(1, out_b, leds_b);
      step();
      chk("t4 fail_vec", int'(fv_a), 0);
      chk("t4 err_cnt", int'(cnt_a), 0);
      chk("t4 mon_state", int'(st_a), 1);
      err_clr = 0; good(0, out_a, leds_a); good(1, out_b, leds_b);
      step();
      chk("t4 drain mon_state", int'(st_a), 0);
      // saturation on the 2-bit counter of instance b
      rst = 1; step();
      rst = 0; enable = 1; opcode = 3'b111;
      for (int k = 0; k < 6; k++) begin
         good(0, out_a, leds_a);
         if (k < 3) good(1, out_b, leds_b);
         else begin out_b = 6'h01; leds_b = leds_h[1][cyc-1]; end
         step();
         if (k == 3) chk("t5 err_cnt first", int'(cnt_b), 2);
      end
      chk("t5 err_cnt sat", int'(cnt_b), 3);
      chk("t5 fail_vec", int'(fv_b), 3'b110);
      chk("t5 mon_state", int'(st_b), 2);
      // reset flushes an in-flight invalid entry of instance b
      rst = 1; enable = 0; step();
      rst = 0; enable = 1; opcode = 3'b111; good(0, out_a, leds_a); good(1, out_b, leds_b); step();
      rst = 1; enable = 0; step();
      rst = 0; enable = 1; opcode = 3'b000; good(0, out_a, leds_a); good(1, out_b, leds_b); step();
      enable = 0; good(0, out_a, leds_a); out_b = 6'h3F; leds_b = 0; step();
      chk("t6 flushed fail_vec", int'(fv_b), 0);
      chk("t6 mon_state busy", int'(st_b), 1);
      for (int k = 0; k < 3; k++) begin
         good(0, out_a, leds_a); good(1, out_b, leds_b); step();
      end
      chk("t6 fail_vec", int'(fv_b), 0);
      chk("t6 mon_state idle", int'(st_b), 0);
      // randomized traffic with occasional misbehaving ALSU outputs
      busy = 1;
      for (int c = 0; c < 1500; c++) begin
         if (c % 40 == 0) busy = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 99) == 0);
         enable = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         err_clr = ($urandom_range(0, 15) == 0);
         opcode = 3'($urandom);
         red_op_A = 1'($urandom);
         red_op_B = 1'($urandom);
         good(0, out_a, leds_a);
         good(1, out_b, leds_b);
         if ($urandom_range(0, 9) == 0) out_a = 6'($urandom);
         if ($urandom_range(0, 9) == 0) leds_a = 16'($urandom);
         if ($urandom_range(0, 9) == 0) out_b = 6'($urandom);
         if ($urandom_range(0, 9) == 0) leds_b = 16'($urandom);
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
